// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_pkg
//  Description : Shared types and default constants for the MIPS memory
//                stage: the bus-handshake state encoding, default bus and
//                timeout sizing, and the MEM/WB register payload.
//  Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

    localparam int c_ADDR_W_DEFAULT  = 30;
    localparam int c_TIMEOUT_DEFAULT = 16;
    localparam int c_CNT_W_DEFAULT   = 5;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_t;

    typedef struct packed {
        logic [31:0] readdata;
        logic [31:0] alures;
        logic [4:0]  muxRegDst;
        logic        regwrite;
        logic        memtoreg;
    } mem_wb_t;

endpackage
`default_nettype wire

// File: rtl/mem_wb_reg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_wb_reg
//  Description : MEM/WB pipeline register. Loads every cycle; a bubble
//                forces the write-back controls low so the slot retires
//                without touching the register file.
//  Ports       : clk, rst  - clock, synchronous active-high reset
//                bubble    - squash regwrite/memtoreg of the loaded entry
//                d / q     - MEM/WB payload in / out
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_wb_reg
    import mips_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    bubble,
    input  mem_wb_t d,
    output mem_wb_t q
);

    mem_wb_t r_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= '0;
        end else begin
            r_q <= d;
            if (bubble) begin
                r_q.regwrite <= 1'b0;
                r_q.memtoreg <= 1'b0;
            end
        end
    end

    assign q = r_q;

endmodule
`default_nettype wire

// File: rtl/mem_stage_stall.sv
`default_nettype none
// ============================================================================
//  Module      : mem_stage_stall
//  Description : MIPS memory stage driving a variable-latency req/ack data
//                bus. Stalls the upstream pipeline while a load or store is
//                outstanding, aborts after a bounded wait, and produces the
//                MEM/WB register contents plus the branch pc_src.
//  Ports       : clk, rst                - clock, synchronous active-high reset
//                m_*                     - EX/MEM register outputs
//                mem_req/we/addr/wdata   - registered bus request
//                mem_rdata, mem_ack      - bus response
//                stall, pc_src           - combinational pipeline controls
//                w_*                     - MEM/WB register outputs
//                bus_err                 - sticky misalign/timeout flag
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_stage_stall
    import mips_pkg::*;
#(
    parameter int ADDR_W  = c_ADDR_W_DEFAULT,
    parameter int TIMEOUT = c_TIMEOUT_DEFAULT,
    parameter int CNT_W   = c_CNT_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       m_alures,
    input  logic [31:0]       m_rd2,
    input  logic [4:0]        m_muxRegDst,
    input  logic              m_regwrite,
    input  logic              m_memtoreg,
    input  logic              m_memread,
    input  logic              m_memwrite,
    input  logic              m_branch,
    input  logic              m_zero,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack,
    output logic              stall,
    output logic              pc_src,
    output logic [31:0]       w_readdata,
    output logic [31:0]       w_alures,
    output logic [4:0]        w_muxRegDst,
    output logic              w_regwrite,
    output logic              w_memtoreg,
    output logic              bus_err
);

    // Last counter value before abort; unused when the timeout is disabled.
    localparam logic [CNT_W-1:0] c_CNT_LAST   = CNT_W'(TIMEOUT - 1);
    localparam bit               c_TIMEOUT_EN = (TIMEOUT != 0);

    mem_state_t        r_state;
    mem_state_t        w_next_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_mem_req;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [31:0]       r_mem_wdata;
    logic              r_bus_err;

    logic              w_acc;
    logic              w_misal;
    logic              w_start;
    logic              w_done;
    logic              w_abort;
    logic              w_bubble;
    logic              w_stall;
    mem_wb_t           w_wb_d;
    mem_wb_t           w_wb_q;

    assign w_acc   = m_memread | m_memwrite;
    assign w_misal = w_acc & (m_alures[1:0] != 2'b00);

    always_comb begin
        w_next_state       = r_state;
        w_stall            = 1'b0;
        w_start            = 1'b0;
        w_done             = 1'b0;
        w_abort            = 1'b0;
        w_bubble           = 1'b0;
        w_wb_d.readdata    = 32'h0;
        w_wb_d.alures      = m_alures;
        w_wb_d.muxRegDst   = m_muxRegDst;
        w_wb_d.regwrite    = m_regwrite;
        w_wb_d.memtoreg    = m_memtoreg;

        case (r_state)
            IDLE: begin
                // Acks arriving here belong to nothing and are dropped.
                if (w_acc && !w_misal) begin
                    w_stall      = 1'b1;
                    w_start      = 1'b1;
                    w_bubble     = 1'b1;
                    w_next_state = WAIT;
                end else if (w_misal) begin
                    w_wb_d.regwrite = 1'b0;
                end
            end
            WAIT: begin
                // Ack takes priority over a timeout on the same cycle.
                if (mem_ack) begin
                    w_done       = 1'b1;
                    w_next_state = IDLE;
                    if (m_memread) begin
                        w_wb_d.readdata = mem_rdata;
                    end
                end else if (c_TIMEOUT_EN && (r_cnt == c_CNT_LAST)) begin
                    w_abort         = 1'b1;
                    w_next_state    = IDLE;
                    w_wb_d.regwrite = 1'b0;
                end else begin
                    w_stall  = 1'b1;
                    w_bubble = 1'b1;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= 32'h0;
            r_cnt       <= '0;
            r_bus_err   <= 1'b0;
        end else begin
            r_state <= w_next_state;

            // Requests only launch from IDLE, so a completed access always
            // leaves at least one cycle with mem_req low before the next.
            if (w_start) begin
                r_mem_req   <= 1'b1;
                r_mem_we    <= m_memwrite;
                r_mem_addr  <= m_alures[ADDR_W+1:2];
                r_mem_wdata <= m_rd2;
            end else if (w_done || w_abort) begin
                r_mem_req <= 1'b0;
            end

            if ((r_state == WAIT) && (w_next_state == WAIT)) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end else begin
                r_cnt <= '0;
            end

            if (((r_state == IDLE) && w_misal) || w_abort) begin
                r_bus_err <= 1'b1;
            end
        end
    end

    mem_wb_reg u_mem_wb_reg (
        .clk    (clk),
        .rst    (rst),
        .bubble (w_bubble),
        .d      (w_wb_d),
        .q      (w_wb_q)
    );

    assign stall       = w_stall;
    assign pc_src      = m_branch & m_zero;
    assign mem_req     = r_mem_req;
    assign mem_we      = r_mem_we;
    assign mem_addr    = r_mem_addr;
    assign mem_wdata   = r_mem_wdata;
    assign bus_err     = r_bus_err;
    assign w_readdata  = w_wb_q.readdata;
    assign w_alures    = w_wb_q.alures;
    assign w_muxRegDst = w_wb_q.muxRegDst;
    assign w_regwrite  = w_wb_q.regwrite;
    assign w_memtoreg  = w_wb_q.memtoreg;

endmodule
`default_nettype wire

// File: doc/mem_stage_stall.md
Name: mem_stage_stall

Overview:
Memory stage for the 5-stage MIPS pipeline that replaces the single-cycle array memory with a request/acknowledge data-memory bus of variable latency. It consumes the EX/MEM pipeline register outputs and produces the MEM/WB register contents for writeback. It computes pc_src for fetch. It asserts stall to freeze the PC, IF/ID, ID/EX and EX/MEM while a load or store is outstanding.

Parameters:
ADDR_W, 30, width of word address on the memory bus; word index = m_alures[ADDR_W+1:2]
TIMEOUT, 16, cycles in WAIT without mem_ack before abort; 0 disables the timeout
CNT_W, 5, width of the timeout counter; must hold TIMEOUT

Ports:
clk  in  1  pipeline clock, rising edge
rst  in  1  synchronous, active-high reset
m_alures  in  32  ALU result, byte address for loads and stores
m_rd2  in  32  store data
m_muxRegDst  in  5  destination register
m_regwrite, m_memtoreg, m_memread, m_memwrite, m_branch, m_zero  in  1 each  EX/MEM control bits
mem_req  out  1  bus request, registered
mem_we  out  1  1 = write, 0 = read; valid while mem_req is high
mem_addr  out  ADDR_W  word address, registered
mem_wdata  out  32  write data, registered
mem_rdata  in  32  read data, sampled on the cycle mem_ack is high
mem_ack  in  1  one-cycle completion pulse
stall  out  1  combinational; freezes all upstream stages
pc_src  out  1  combinational, m_branch & m_zero
w_readdata, w_alures  out  32 each  MEM/WB data
w_muxRegDst  out  5  MEM/WB destination register
w_regwrite, w_memtoreg  out  1 each  MEM/WB control bits
bus_err  out  1  sticky error flag

Behaviour:
- States: IDLE, WAIT.
- acc = m_memread | m_memwrite. misal = acc & (m_alures[1:0] != 0).
- Reset: state IDLE; mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, counter=0, bus_err=0; all w_* = 0.
- Reset mid-transaction: mem_req drops on the reset edge. Any mem_ack after reset is ignored.
- Non-access instruction (acc=0), state IDLE: stall=0; MEM/WB loads {readdata 0, alures, dst, regwrite, memtoreg}. Latency 1 cycle.
- Misaligned access, state IDLE: no bus request; stall=0; bus_err<=1. MEM/WB loads with w_regwrite=0.
- Aligned access, state IDLE: stall=1.
  - Next state WAIT.
  - mem_req<=1, mem_we<=m_memwrite, mem_addr<=word index, mem_wdata<=m_rd2.
  - MEM/WB loads a bubble: w_regwrite=0, w_memtoreg=0.
- WAIT:
  - mem_req, mem_we, mem_addr and mem_wdata stay stable.
  - If mem_ack: stall=0; mem_req<=0; state<=IDLE.
    - MEM/WB loads readdata = m_memread ? mem_rdata : 0, plus that instruction's alures and controls.
    - Minimum access latency is 2 cycles.
  - If no mem_ack: stall=1; counter increments; MEM/WB loads a bubble.
  - If TIMEOUT != 0 and counter == TIMEOUT-1 without ack: abort.
    - stall=0, mem_req<=0, bus_err<=1, state<=IDLE.
    - Instruction completes with readdata 0 and w_regwrite=0.
  - Counter clears on every entry to IDLE.
- mem_ack while in IDLE: ignored.
- A back-to-back access entering IDLE on the cycle after completion starts a new request. Every access gets at least one cycle with mem_req low between requests.
- pc_src is independent of stall; branches never access memory.
- bus_err clears only on reset.

Decomposition:
- Package mips_pkg:
  - state enum {IDLE, WAIT}
  - default ADDR_W/TIMEOUT constants
  - a struct grouping the MEM/WB fields (readdata, alures, muxRegDst, regwrite, memtoreg)
- Sub-module mem_wb_reg: MEM/WB register with synchronous reset and a bubble input forcing regwrite/memtoreg to 0.
- FSM and bus logic live in the top module.

Test Plan:
- ALU op: alures=0x0000_0010, dst=9, regwrite=1, no access -> stall=0; next cycle w_alures=0x10, w_muxRegDst=9, w_regwrite=1, mem_req never high.
- Load at 0x0000_0008 with ack after 3 WAIT cycles, rdata=0xDEAD_BEEF:
  - mem_addr=2, mem_we=0.
  - stall high for 4 cycles.
  - w_readdata=0xDEADBEEF and w_memtoreg=1 only on the cycle after ack.
  - Bubbles before that.
- Store 0x1234_5678 to 0x0000_000C with ack after 1 WAIT cycle -> mem_we=1, mem_addr=3, mem_wdata=0x12345678; stall 2 cycles; bus_err=0.
- Load at 0x0000_0006 -> no mem_req; bus_err=1; w_regwrite=0; stall=0.
- TIMEOUT=4, no ack -> stall released after 4 WAIT cycles; bus_err=1; w_regwrite=0; mem_req low.
- rst asserted during WAIT, then ack pulses -> mem_req=0, all w_*=0, state IDLE; ack ignored, no MEM/WB update.
